// File: rtl/pnp_rom_ctrl.sv
// pnp_rom_ctrl: parametrised Plug-and-Play descriptor ROM behind an Avalon-MM slave, with post-reset checksum scan.
// Ports:
//   clk, reset_n          single rising-edge clock, asynchronous active-low reset
//   address, chipselect,  Avalon-MM slave request (word address)
//   read, write,
//   writedata, byteenable,
//   debugaccess           debugaccess qualifies writes
//   clken, reset_req      global enable is clken & ~reset_req; when it is low all state holds
//   rescan                pulse in READY restarts the integrity scan
//   waitrequest           high while the scan owns the memory
//   readdata, readdatavalid  read response, READ_LATENCY enabled edges after acceptance
//   checksum, checksum_valid sum of all words modulo 2**DATA_WIDTH, and whether it is current
// Optional feature macro PNP_ROM_WRITE_EN builds the debug byte-lane write path;
// without it the memory is read-only and the write-side ports are ignored.
module pnp_rom_ctrl #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 10,
  parameter int    DEPTH        = 1024,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "./PnP_ROM/PnP_ROM.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    debugaccess,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic                    rescan,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic [DATA_WIDTH-1:0]   checksum,
  output logic                    checksum_valid
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LAST_C = DEPTH_C - 1'b1;
  localparam logic [0:0] ST_SCAN = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  // Contents come from INIT_FILE at device configuration; the array itself is never reset.
  (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [0:0]            r_state;
  logic [ADDR_WIDTH:0]   r_scnt;
  logic [DATA_WIDTH-1:0] r_acc, r_chk, r_q1, r_rdata;
  logic                  r_hv1, r_sv1, r_sl1, r_rvalid, r_cv;
  logic                  w_en, w_scan, w_sissue, w_slast, w_hacc, w_rd_in, w_we;
  logic                  w_hv, w_sv, w_sl;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_rd, w_d;
  // One shared read port: the scan drives it while waitrequest is high, the host otherwise.
  // w_d/w_hv/w_sv/w_sl are what enters the output stage on this edge; with latency 1 that is
  // the memory itself, with latency 2 it is the intermediate register.
  always_comb begin
    w_en     = clken & ~reset_req;
    w_scan   = (r_state == ST_SCAN);
    w_sissue = w_scan & (r_scnt < DEPTH_C);
    w_slast  = w_sissue & (r_scnt == LAST_C);
    w_hacc   = chipselect & read & ~write & ~w_scan;
    w_addr   = w_scan ? r_scnt[ADDR_WIDTH-1:0] : address;
    w_rd_in  = ({1'b0, w_addr} < DEPTH_C);
    w_rd     = w_rd_in ? r_mem[w_addr[IW-1:0]] : '0;
    w_d      = (READ_LATENCY == 1) ? w_rd : r_q1;
    w_hv     = (READ_LATENCY == 1) ? w_hacc : r_hv1;
    w_sv     = (READ_LATENCY == 1) ? w_sissue : r_sv1;
    w_sl     = (READ_LATENCY == 1) ? w_slast : r_sl1;
  end
`ifdef PNP_ROM_WRITE_EN
  assign w_we = chipselect & write & debugaccess & ~w_scan & w_en & ({1'b0, address} < DEPTH_C);
`else
  logic w_unused_dbg;
  assign w_unused_dbg = debugaccess;
  assign w_we = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (w_we)
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (byteenable[b]) r_mem[address[IW-1:0]][b*8 +: 8] <= writedata[b*8 +: 8];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_SCAN;
      r_scnt   <= '0;
      r_acc    <= '0;
      r_chk    <= '0;
      r_cv     <= 1'b0;
      r_q1     <= '0;
      r_hv1    <= 1'b0;
      r_sv1    <= 1'b0;
      r_sl1    <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else if (w_en) begin
      r_q1     <= w_rd;
      r_hv1    <= w_hacc;
      r_sv1    <= w_sissue;
      r_sl1    <= w_slast;
      r_rdata  <= w_d;
      r_rvalid <= w_hv;
      if (w_scan) begin
        r_scnt <= r_scnt + {{ADDR_WIDTH{1'b0}}, w_sissue};
        if (w_sv) r_acc <= r_acc + w_d;
        if (w_sv && w_sl) begin
          r_chk   <= r_acc + w_d;
          r_cv    <= 1'b1;
          r_state <= ST_READY;
        end
      end else if (rescan) begin
        r_state <= ST_SCAN;
        r_scnt  <= '0;
        r_acc   <= '0;
        r_cv    <= 1'b0;
      end else if (w_we) r_cv <= 1'b0;
    end
  end
  assign waitrequest    = w_scan;
  assign readdata       = r_rdata;
  assign readdatavalid  = r_rvalid;
  assign checksum       = r_chk;
  assign checksum_valid = r_cv;
endmodule

// File: tb/tb_pnp_rom_ctrl.sv
// tb_pnp_rom_ctrl: randomized self-checking bench for pnp_rom_ctrl against a transaction-level model.
module tb_pnp_rom_ctrl;
  localparam int DW = 32, AW = 5, DEPTH = 16, RL = 2;
`ifdef PNP_ROM_WRITE_EN
  localparam bit WE = 1'b1;
`else
  localparam bit WE = 1'b0;
`endif
  logic          clk = 1'b0, reset_n = 1'b0;
  logic [AW-1:0] address;
  logic [DW/8-1:0] byteenable;
  logic          chipselect, read, write, debugaccess, clken, reset_req, rescan;
  logic [DW-1:0] writedata, readdata, checksum;
  logic          waitrequest, readdatavalid, checksum_valid;
  int n_checks = 0, n_fail = 0;
  typedef struct { logic [DW-1:0] d; int left; } pend_t;
  pend_t         pend[$];
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_scan, m_cv, m_rv;
  logic [DW-1:0] m_ck, m_rd;
  int            m_cnt;
  pnp_rom_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .debugaccess(debugaccess), .clken(clken), .reset_req(reset_req), .rescan(rescan),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .checksum(checksum), .checksum_valid(checksum_valid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] mem_sum();
    logic [DW-1:0] s = '0;
    for (int i = 0; i < DEPTH; i++) s += m_mem[i];
    return s;
  endfunction
  task automatic model_reset();
    m_scan = 1'b1; m_cnt = 0; m_cv = 1'b0; m_ck = '0; m_rv = 1'b0; m_rd = '0;
    pend.delete();
  endtask
  // One enabled edge: accept, age the outstanding reads, apply writes, advance the scan/ready state.
  task automatic model_edge();
    pend_t e;
    logic  we, in_range;
    if (!(clken && !reset_req)) return;
    in_range = int'(address) < DEPTH;
    if (chipselect && read && !write && !m_scan) begin
      e.d = in_range ? m_mem[address[3:0]] : '0;
      e.left = RL;
      pend.push_back(e);
    end
    m_rv = 1'b0;
    foreach (pend[i]) pend[i].left--;
    if (pend.size() > 0 && pend[0].left == 0) begin
      m_rv = 1'b1;
      m_rd = pend[0].d;
      void'(pend.pop_front());
    end
    we = WE && chipselect && write && debugaccess && !m_scan && in_range;
    if (we)
      for (int b = 0; b < DW/8; b++)
        if (byteenable[b]) m_mem[address[3:0]][8*b +: 8] = writedata[8*b +: 8];
    if (m_scan) begin
      m_cnt++;
      if (m_cnt == DEPTH + RL - 1) begin
        m_ck = mem_sum(); m_cv = 1'b1; m_scan = 1'b0;
      end
    end else if (rescan) begin
      m_scan = 1'b1; m_cnt = 0; m_cv = 1'b0;
    end else if (we) m_cv = 1'b0;
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("waitrequest", 32'(waitrequest), 32'(m_scan));
    check("readdatavalid", 32'(readdatavalid), 32'(m_rv));
    check("checksum_valid", 32'(checksum_valid), 32'(m_cv));
    check("checksum", checksum, m_ck);
    if (m_rv) check("readdata", readdata, m_rd);
  endtask
  task automatic steps(input int n);
    repeat (n) step();
  endtask
  task automatic idle();
    chipselect = 0; read = 0; write = 0; rescan = 0; debugaccess = 0;
    address = '0; writedata = '0; byteenable = '0;
  endtask
  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    #1;
    check("rst_wait", 32'(waitrequest), 32'd1);
    check("rst_rvalid", 32'(readdatavalid), 32'd0);
    check("rst_rdata", readdata, 32'd0);
    check("rst_ck", checksum, 32'd0);
    check("rst_cv", 32'(checksum_valid), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic rd1(input logic [AW-1:0] a, input string tag, input logic [DW-1:0] exp);
    chipselect = 1; read = 1; address = a;
    step();
    idle();
    steps(RL - 1);
    check(tag, readdata, exp);
  endtask
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be, input logic dbg);
    chipselect = 1; write = 1; address = a; writedata = d; byteenable = be; debugaccess = dbg;
    step();
    idle();
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      dut.r_mem[i] = 32'(i + 1);
      m_mem[i] = 32'(i + 1);
    end
    clken = 1; reset_req = 0;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    do_reset();
    steps(DEPTH + RL + 1);
    check("ck_init", checksum, 32'h88);
    chipselect = 1; read = 1; address = 3; step();
    address = 4; step();
    address = 5; step();
    address = 20; step();
    idle(); steps(3);
    rd1(20, "rd_oor", 32'h0);
    rd1(7, "rd_7", 32'h8);
    do_write(0, 32'hFFFF_FFFF, 4'b0001, 1'b1);
    check("cv_after_wr", 32'(checksum_valid), WE ? 32'd0 : 32'd1);
    rd1(0, "rd_wr", WE ? 32'hFF : 32'h1);
    rescan = 1; step(); rescan = 0;
    steps(DEPTH + RL);
    check("ck_rescan", checksum, WE ? 32'h186 : 32'h88);
    do_write(1, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    rd1(1, "rd_nodbg", 32'h2);
    rescan = 1; step(); rescan = 0;
    steps(5);
    clken = 0; steps(5); clken = 1;
    steps(DEPTH + RL);
    chipselect = 1; read = 1; address = 2; step();
    address = 3; step();
    idle(); reset_req = 1; steps(3); reset_req = 0;
    steps(3);
    rescan = 1; step(); rescan = 0;
    steps(4);
    do_reset();
    steps(DEPTH + RL + 1);
    chipselect = 1; read = 1; address = 5; step();
    idle();
    do_reset();
    steps(DEPTH + RL + 1);
    repeat (600) begin
      clken       = ($urandom_range(9) != 0);
      reset_req   = ($urandom_range(9) == 0);
      rescan      = ($urandom_range(29) == 0);
      chipselect  = ($urandom_range(3) != 0);
      read        = 1'($urandom_range(1));
      write       = ($urandom_range(5) == 0);
      debugaccess = 1'($urandom_range(1));
      address     = 5'($urandom_range(31));
      writedata   = $urandom;
      byteenable  = 4'($urandom_range(15));
      step();
    end
    idle(); clken = 1; reset_req = 0;
    steps(DEPTH + RL + 3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
